// File: rtl/inst_fetch_queue.sv
// Instruction prefetch FIFO between the PC/ROM fetch stage and decode.
// Buffers {PC, instruction} pairs, raises Hold when full, and drops everything on Flush.
module inst_fetch_queue #(
    parameter int unsigned IW    = 9,
    parameter int unsigned AW    = 10,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       InValid,
    input  logic [AW-1:0]              InPC,
    input  logic [IW-1:0]              InInst,
    input  logic                       Flush,
    input  logic                       OutReady,
    output logic                       OutValid,
    output logic [AW-1:0]              OutPC,
    output logic [IW-1:0]              OutInst,
    output logic                       Hold,
    output logic [$clog2(DEPTH):0]     Count,
    output logic                       DropErr
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [AW-1:0] pc_mem   [DEPTH];
    logic [IW-1:0] inst_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic          drop_err;
    logic          push;
    logic          pop;

    // Status and head entry come straight from registered state; no bypass path.
    assign OutValid = (count != '0);
    assign Hold     = (count == CW'(DEPTH));
    assign OutPC    = pc_mem[rd_ptr];
    assign OutInst  = inst_mem[rd_ptr];
    assign Count    = count;
    assign DropErr  = drop_err;

    assign push = InValid & ~Hold & ~Flush;
    assign pop  = OutValid & OutReady;

    // Occupancy update for the non-flush case.
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end
    end

    // Storage write; contents survive a flush and are only zeroed by reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pc_mem[i]   <= '0;
                inst_mem[i] <= '0;
            end
        end else if (push) begin
            pc_mem[wr_ptr]   <= InPC;
            inst_mem[wr_ptr] <= InInst;
        end
    end

    // Pointers, occupancy and sticky drop flag; Flush overrides push and pop.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            drop_err <= 1'b0;
        end else begin
            if (Flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PW'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count_nxt;
            end
            if (InValid && Hold && !Flush) begin
                drop_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: queue-based reference model with per-cycle compare,
// directed scenarios pinned by literal expectations, then randomized traffic.
module tb_inst_fetch_queue;

    localparam int unsigned IW    = 9;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 4;

    logic          Clk;
    logic          Reset;
    logic          InValid;
    logic [AW-1:0] InPC;
    logic [IW-1:0] InInst;
    logic          Flush;
    logic          OutReady;
    logic          OutValid;
    logic [AW-1:0] OutPC;
    logic [IW-1:0] OutInst;
    logic          Hold;
    logic [2:0]    Count;
    logic          DropErr;

    inst_fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InValid  (InValid),
        .InPC     (InPC),
        .InInst   (InInst),
        .Flush    (Flush),
        .OutReady (OutReady),
        .OutValid (OutValid),
        .OutPC    (OutPC),
        .OutInst  (OutInst),
        .Hold     (Hold),
        .Count    (Count),
        .DropErr  (DropErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: an ordered list of accepted entries plus the sticky drop flag.
    typedef struct packed {
        logic [AW-1:0] pc;
        logic [IW-1:0] inst;
    } ent_t;

    ent_t mq[$];
    logic m_drop;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            mq.delete();
            m_drop = 1'b0;
        end else begin
            automatic bit full = (mq.size() == DEPTH);
            automatic bit acc  = InValid && !full && !Flush;
            automatic bit take = (mq.size() != 0) && OutReady;
            if (InValid && full && !Flush) m_drop = 1'b1;
            if (Flush) begin
                mq.delete();
            end else begin
                if (take) void'(mq.pop_front());
                if (acc) mq.push_back('{pc: InPC, inst: InInst});
            end
        end
    end

    // Per-cycle compare against the model, away from the rising edge.
    always @(negedge Clk) begin
        if (Reset) begin
            chk("count", int'(Count), mq.size());
            chk("count_le_depth", int'(Count <= 3'(DEPTH)), 1);
            chk("out_valid", int'(OutValid), int'(mq.size() != 0));
            chk("hold", int'(Hold), int'(mq.size() == DEPTH));
            chk("drop_err", int'(DropErr), int'(m_drop));
            if (mq.size() != 0) begin
                chk("out_pc", int'(OutPC), int'(mq[0].pc));
                chk("out_inst", int'(OutInst), int'(mq[0].inst));
            end
        end
    end

    // Apply inputs for one cycle; returns at the following falling edge.
    task automatic cyc(input logic v, input int pc, input int inst, input logic rdy, input logic fl);
        InValid  = v;
        InPC     = AW'(pc);
        InInst   = IW'(inst);
        OutReady = rdy;
        Flush    = fl;
        @(negedge Clk);
    endtask

    task automatic do_reset();
        InValid = 1'b0; Flush = 1'b0; OutReady = 1'b0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0; InValid = 1'b0; InPC = '0; InInst = '0; Flush = 1'b0; OutReady = 1'b0;
        repeat (2) @(negedge Clk);
        chk("rst_count", int'(Count), 0);
        chk("rst_valid", int'(OutValid), 0);
        chk("rst_hold", int'(Hold), 0);
        chk("rst_pc", int'(OutPC), 0);
        chk("rst_inst", int'(OutInst), 0);
        chk("rst_drop", int'(DropErr), 0);
        Reset = 1'b1;

        // Asynchronous reset mid-stream with three entries queued.
        for (int i = 0; i < 3; i++) cyc(1'b1, 16'h30 + i, 9'h0AA + i, 1'b0, 1'b0);
        chk("t1_count3", int'(Count), 3);
        InValid = 1'b0;
        #2 Reset = 1'b0;
        #1;
        chk("t1_async_count", int'(Count), 0);
        chk("t1_async_valid", int'(OutValid), 0);
        chk("t1_async_hold", int'(Hold), 0);
        chk("t1_async_pc", int'(OutPC), 0);
        chk("t1_async_inst", int'(OutInst), 0);
        @(negedge Clk);
        Reset = 1'b1;
        cyc(1'b1, 10'h005, 9'h055, 1'b0, 1'b0);
        chk("t1_valid", int'(OutValid), 1);
        chk("t1_pc", int'(OutPC), 10'h005);

        // Fill to full, attempt an overflow, then drain in order.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, i, 9'h101 + i, 1'b0, 1'b0);
        chk("t2_count4", int'(Count), 4);
        chk("t2_hold", int'(Hold), 1);
        cyc(1'b1, 4, 9'h105, 1'b0, 1'b0);
        chk("t2_drop", int'(DropErr), 1);
        chk("t2_count_still4", int'(Count), 4);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t2_hold_drop", int'(Hold), 0);
        chk("t2_head1", int'(OutPC), 1);
        chk("t2_inst1", int'(OutInst), 9'h102);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t2_empty", int'(OutValid), 0);

        // Streaming with decode always ready: one-cycle latency, pointers wrap.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cyc(1'b1, i, 9'h050 + i, 1'b1, 1'b0);
            chk("t3_pc", int'(OutPC), i);
            chk("t3_count1", int'(Count), 1);
            chk("t3_nohold", int'(Hold), 0);
        end
        cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t3_drained", int'(Count), 0);

        // Flush with a concurrent pop and a concurrent fetch.
        do_reset();
        for (int i = 7; i < 10; i++) cyc(1'b1, i, 9'h070 + i, 1'b0, 1'b0);
        chk("t4_head7", int'(OutPC), 7);
        cyc(1'b1, 10, 9'h1AA, 1'b1, 1'b1);
        chk("t4_count0", int'(Count), 0);
        chk("t4_valid0", int'(OutValid), 0);
        chk("t4_nodrop", int'(DropErr), 0);
        cyc(1'b0, 0, 0, 1'b1, 1'b1);
        chk("t4_still_empty", int'(OutValid), 0);

        // Full queue: pop and rejected push in the same cycle.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b1, 16'h20 + i, 9'h120 + i, 1'b0, 1'b0);
        cyc(1'b1, 10'h3FE, 9'h1FE, 1'b1, 1'b0);
        chk("t5_count3", int'(Count), 3);
        chk("t5_drop", int'(DropErr), 1);
        chk("t5_hold0", int'(Hold), 0);
        chk("t5_head", int'(OutPC), 16'h21);
        cyc(1'b1, 10'h3FF, 9'h1FF, 1'b0, 1'b0);
        chk("t5_count4", int'(Count), 4);
        for (int i = 0; i < 3; i++) cyc(1'b0, 0, 0, 1'b1, 1'b0);
        chk("t5_last_pc", int'(OutPC), 10'h3FF);
        chk("t5_last_inst", int'(OutInst), 9'h1FF);
        cyc(1'b0, 0, 0, 1'b1, 1'b0);

        // Randomized traffic checked cycle by cycle by the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            cyc(1'(($urandom % 4) != 0), int'($urandom % 1024), int'($urandom % 512),
                1'($urandom % 2), 1'(($urandom % 32) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
